// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter (core load/store path vs. external debug/DMA).
// Define DMEM_ARB_RR_EN for round-robin on simultaneous requests; default is core-first.
module dmem_arbiter (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        core_req_in,
  input  logic        core_wr_in,
  input  logic [31:0] core_addr_in,
  input  logic [31:0] core_wdata_in,
  input  logic [3:0]  core_mask_in,
  input  logic        ext_req_in,
  input  logic        ext_wr_in,
  input  logic [31:0] ext_addr_in,
  input  logic [31:0] ext_wdata_in,
  input  logic [3:0]  ext_mask_in,
  output logic        core_gnt_out,
  output logic        core_done_out,
  output logic [31:0] core_rdata_out,
  output logic        ext_gnt_out,
  output logic        ext_done_out,
  output logic [31:0] ext_rdata_out,
  output logic        mem_req_out,
  output logic        mem_wr_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_mask_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_rdata_in
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_CORE, OWN_EXT} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  mask_q;
  logic        core_gnt_q, ext_gnt_q, core_done_q, ext_done_q;
  logic [31:0] core_rdata_q, ext_rdata_q;
  logic        capture, win_ext, ack_fire, ext_prio;

`ifdef DMEM_ARB_RR_EN
  owner_t last_q;
  assign ext_prio = (last_q == OWN_CORE);
  always_ff @(posedge clk_in) begin
    if (reset_in)     last_q <= OWN_EXT;
    else if (capture) last_q <= win_ext ? OWN_EXT : OWN_CORE;
  end
`else
  assign ext_prio = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    win_ext = 1'b0;
    case (state_q)
      IDLE: if (core_req_in || ext_req_in) begin
        capture = 1'b1;
        win_ext = ext_req_in && (!core_req_in || ext_prio);
        state_d = BUSY;
      end
      BUSY: if (mem_ack_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ack_fire = (state_q == BUSY) && mem_ack_in;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CORE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      core_gnt_q   <= 1'b0;
      ext_gnt_q    <= 1'b0;
      core_done_q  <= 1'b0;
      ext_done_q   <= 1'b0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      core_gnt_q  <= capture && !win_ext;
      ext_gnt_q   <= capture && win_ext;
      core_done_q <= ack_fire && (owner_q == OWN_CORE);
      ext_done_q  <= ack_fire && (owner_q == OWN_EXT);
      if (capture) begin
        // Reads never drive byte lanes; address is forced word-aligned.
        owner_q <= win_ext ? OWN_EXT : OWN_CORE;
        wr_q    <= win_ext ? ext_wr_in : core_wr_in;
        addr_q  <= (win_ext ? ext_addr_in : core_addr_in) & 32'hFFFF_FFFC;
        wdata_q <= win_ext ? ext_wdata_in : core_wdata_in;
        mask_q  <= win_ext ? (ext_wr_in ? ext_mask_in : 4'b0000)
                           : (core_wr_in ? core_mask_in : 4'b0000);
      end
      if (ack_fire && owner_q == OWN_CORE) core_rdata_q <= wr_q ? 32'h0 : mem_rdata_in;
      if (ack_fire && owner_q == OWN_EXT)  ext_rdata_q  <= wr_q ? 32'h0 : mem_rdata_in;
    end
  end

  assign core_gnt_out   = core_gnt_q;
  assign ext_gnt_out    = ext_gnt_q;
  assign core_done_out  = core_done_q;
  assign ext_done_out   = ext_done_q;
  assign core_rdata_out = core_rdata_q;
  assign ext_rdata_out  = ext_rdata_q;
  assign mem_req_out    = (state_q == BUSY);
  assign mem_wr_out     = wr_q;
  assign mem_addr_out   = addr_q;
  assign mem_wdata_out  = wdata_q;
  assign mem_mask_out   = mask_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single transactions with a scoreboard,
// plus sequences for contention, reset-while-busy and spurious acks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        core_req, core_wr, ext_req, ext_wr;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
  logic [3:0]  core_mask, ext_mask;
  logic        core_gnt, core_done, ext_gnt, ext_done;
  logic [31:0] core_rdata, ext_rdata;
  logic        mem_req, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk_in(clk), .reset_in(reset_in),
    .core_req_in(core_req), .core_wr_in(core_wr), .core_addr_in(core_addr),
    .core_wdata_in(core_wdata), .core_mask_in(core_mask),
    .ext_req_in(ext_req), .ext_wr_in(ext_wr), .ext_addr_in(ext_addr),
    .ext_wdata_in(ext_wdata), .ext_mask_in(ext_mask),
    .core_gnt_out(core_gnt), .core_done_out(core_done), .core_rdata_out(core_rdata),
    .ext_gnt_out(ext_gnt), .ext_done_out(ext_done), .ext_rdata_out(ext_rdata),
    .mem_req_out(mem_req), .mem_wr_out(mem_wr), .mem_addr_out(mem_addr),
    .mem_wdata_out(mem_wdata), .mem_mask_out(mem_mask),
    .mem_ack_in(mem_ack), .mem_rdata_in(mem_rdata)
  );

  typedef struct {
    bit          who;      // 0 core, 1 ext
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          delay;    // BUSY cycles before ack beyond the first
    logic [31:0] mrdata;   // data memory returns
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          who;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Protocol invariants watched every cycle outside reset.
  always @(negedge clk) begin
    if (reset_in === 1'b0) begin
      checks++;
      if ((core_gnt && ext_gnt) || (core_done && ext_done)) begin
        errors++;
        $display("FAIL exclusive: gnt=%b%b done=%b%b expected at most one of each",
                 core_gnt, ext_gnt, core_done, ext_done);
      end
    end
  end

  task automatic idle_inputs();
    core_req = 0; core_wr = 0; core_addr = 0; core_wdata = 0; core_mask = 0;
    ext_req = 0; ext_wr = 0; ext_addr = 0; ext_wdata = 0; ext_mask = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    reset_in = 1;
    step();
    step();
    reset_in = 0;
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_outs"}, {28'h0, core_gnt, ext_gnt, core_done, ext_done}, 32'h0);
    check({tag, "_memreq"}, {31'h0, mem_req}, 32'h0);
  endtask

  task automatic run_vec(vec_t v);
    exp_t e;
    int n;
    e.who = v.who;
    e.rdata = v.exp_rdata;
    sb.push_back(e);
    if (v.who == 0) begin
      core_req = 1; core_wr = v.wr; core_addr = v.addr; core_wdata = v.wdata; core_mask = v.mask;
    end else begin
      ext_req = 1; ext_wr = v.wr; ext_addr = v.addr; ext_wdata = v.wdata; ext_mask = v.mask;
    end
    n = 0;
    step();
    while (!(v.who ? ext_gnt : core_gnt) && n < 8) begin
      step();
      n++;
    end
    check("gnt_latency", n, 0);
    check("gnt_other", {31'h0, v.who ? core_gnt : ext_gnt}, 32'h0);
    core_req = 0; ext_req = 0;
    core_addr = 32'h5A5A_5A5A; ext_addr = 32'hA5A5_A5A5;
    core_wdata = 32'hFFFF_FFFF; ext_wdata = 32'hFFFF_FFFF;
    for (int k = 0; k <= v.delay; k++) begin
      if (k > 0) begin
        step();
        check("gnt_pulse", {30'h0, core_gnt, ext_gnt}, 32'h0);
      end
      check("busy_req", {31'h0, mem_req}, 32'h1);
      check("busy_wr", {31'h0, mem_wr}, {31'h0, v.wr});
      check("busy_addr", mem_addr, v.exp_addr);
      check("busy_wdata", mem_wdata, v.wdata);
      check("busy_mask", {28'h0, mem_mask}, {28'h0, v.exp_mask});
      check("busy_nodone", {30'h0, core_done, ext_done}, 32'h0);
    end
    mem_ack = 1;
    mem_rdata = v.mrdata;
    step();
    mem_ack = 0;
    mem_rdata = 32'h1357_9BDF;
    e = sb.pop_front();
    check("done_owner", {30'h0, core_done, ext_done}, e.who ? 32'h1 : 32'h2);
    check("done_rdata", e.who ? ext_rdata : core_rdata, e.rdata);
    check("req_drop", {31'h0, mem_req}, 32'h0);
    step();
    check("done_pulse", {30'h0, core_done, ext_done}, 32'h0);
  endtask

  vec_t vecs[6];

  initial begin
    bit exp_ext;
    int n;
    vecs[0] = '{0, 0, 32'h0000_1007, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 32'h0000_1004, 4'h0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 3, 32'hCAFE_0001, 32'h0000_0020, 4'b0010, 32'h0};
    vecs[2] = '{0, 1, 32'h0000_0003, 32'h1234_5678, 4'b0101, 0, 32'hFFFF_0000, 32'h0000_0000, 4'b0101, 32'h0};
    vecs[3] = '{1, 0, 32'hFFFF_FFFF, 32'h0, 4'hF, 2, 32'h8000_0001, 32'hFFFF_FFFC, 4'h0, 32'h8000_0001};
    vecs[4] = '{0, 1, 32'h8000_0100, 32'hA5A5_5A5A, 4'hF, 1, 32'h0BAD_F00D, 32'h8000_0100, 4'hF, 32'h0};
    vecs[5] = '{1, 0, 32'h0000_0446, 32'h0, 4'h0, 0, 32'h7654_3210, 32'h0000_0444, 4'h0, 32'h7654_3210};

    idle_inputs();
    do_reset();
    check_quiet("reset");
    check("reset_addr", mem_addr, 32'h0);
    check("reset_wdata", mem_wdata, 32'h0);
    check("reset_rdata", core_rdata | ext_rdata, 32'h0);
    check("reset_mask", {27'h0, mem_wr, mem_mask}, 32'h0);

    // Spurious ack in IDLE must be ignored.
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("spurious");
      check("spurious_rdata", core_rdata | ext_rdata, 32'h0);
    end
    mem_ack = 0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both masters request continuously.
    do_reset();
    core_req = 1; core_wr = 0; core_addr = 32'h100;
    ext_req = 1; ext_wr = 0; ext_addr = 32'h200;
    for (int g = 0; g < 4; g++) begin
`ifdef DMEM_ARB_RR_EN
      exp_ext = (g % 2) == 1;
`else
      exp_ext = 0;
`endif
      n = 0;
      step();
      while (!(core_gnt || ext_gnt) && n < 6) begin
        step();
        n++;
      end
      check("contend_gnt", {30'h0, core_gnt, ext_gnt}, exp_ext ? 32'h1 : 32'h2);
      check("contend_addr", mem_addr, exp_ext ? 32'h200 : 32'h100);
      mem_ack = 1;
      step();
      mem_ack = 0;
      check("contend_done", {30'h0, core_done, ext_done}, exp_ext ? 32'h1 : 32'h2);
    end
    core_req = 0; ext_req = 0;
    step();
    step();

    // Reset while BUSY abandons the access.
    core_req = 1; core_wr = 1; core_addr = 32'h40; core_wdata = 32'h1111_2222; core_mask = 4'hF;
    step();
    check("rst_busy_gnt", {31'h0, core_gnt}, 32'h1);
    core_req = 0;
    reset_in = 1;
    step();
    reset_in = 0;
    check_quiet("rst_busy");
    mem_ack = 1; mem_rdata = 32'hEEEE_EEEE;
    step();
    check_quiet("rst_late_ack");
    mem_ack = 0;
    step();
    check_quiet("rst_after");
    check("rst_rdata", core_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL use one clock and one reset: clk_in, input, 1, system clock (all state on rising edge).
REQ-002 reset_in, input, 1, reset, synchronous and active-high.
REQ-003 core_req_in / ext_req_in, input, 1 each, access request from core load-store path / external (debug/DMA) master.
REQ-004 core_wr_in / ext_wr_in, input, 1 each, 1 = write, 0 = read.
REQ-005 core_addr_in / ext_addr_in, input, 32 each, word-aligned address (bits [1:0] ignored, forced 00 on output).
REQ-006 core_wdata_in / ext_wdata_in, input, 32 each, lane-aligned write data.
REQ-007 core_mask_in / ext_mask_in, input, 4 each, byte-lane write mask.
REQ-008 core_gnt_out / ext_gnt_out, output, 1 each, one-cycle pulse: request captured.
REQ-009 core_done_out / ext_done_out, output, 1 each, one-cycle pulse: access complete.
REQ-010 core_rdata_out / ext_rdata_out, output, 32 each, read data, valid while matching done_out is high.
REQ-011 mem_req_out, mem_wr_out, output, 1 each, memory request and direction.
REQ-012 mem_addr_out, mem_wdata_out, output, 32 each; mem_mask_out, output, 4.
REQ-013 mem_ack_in, input, 1, memory completed current request; mem_rdata_in, input, 32, read data valid with mem_ack_in.

Function
REQ-014 FSM states SHALL be IDLE and BUSY; owner register (CORE/EXT) SHALL record the current requester.
REQ-015 In IDLE, at a clock edge with any req high: SHALL select a winner, register its wr/addr/wdata/mask, record owner, go to BUSY.
REQ-016 The cycle after capture: winner gnt_out SHALL pulse high for exactly one cycle; mem_req_out SHALL be high and driven from registered fields.
REQ-017 Requester SHALL hold req and fields stable until its gnt_out; the arbiter SHALL ignore fields after capture.
REQ-018 In BUSY, mem_req_out and all mem_* fields SHALL stay constant until mem_ack_in is sampled high.
REQ-019 mem_ack_in in the first BUSY cycle SHALL be legal (minimum occupancy one cycle).
REQ-020 On ack edge: state SHALL return to IDLE, mem_req_out SHALL drop next cycle, owner done_out SHALL pulse next cycle, owner rdata_out SHALL take registered mem_rdata_in (reads); for writes rdata_out SHALL be 0.
REQ-021 Re-arbitration SHALL occur at the first IDLE edge; back-to-back throughput is one access per two cycles minimum.
REQ-022 For reads, mem_mask_out SHALL be 4'b0000 regardless of requester mask; mem_addr_out[1:0] SHALL be 2'b00.
REQ-023 mem_ack_in while IDLE SHALL be ignored (no done pulse, no state change).
REQ-024 Non-owner gnt_out/done_out SHALL stay low throughout; never both gnt_out or both done_out high in one cycle.

Reset
REQ-025 With reset_in high at an edge: state IDLE, mem_req_out 0, all gnt/done 0, all rdata/mem_* data 0, last-served marker = EXT.
REQ-026 Reset during BUSY SHALL abandon the transaction with no done pulse; a requester re-issues after reset.

Configuration
REQ-027 Macro DMEM_ARB_RR_EN defined: simultaneous requests SHALL be granted to the requester not served last (round-robin, 1-bit last-served marker updated at each capture).
REQ-028 DMEM_ARB_RR_EN undefined: core SHALL always win simultaneous requests (fixed priority); no marker logic.

Verification
REQ-029 Core read addr 0x0000_1007, mem acks first BUSY cycle with 0xDEAD_BEEF -> mem_addr_out 0x0000_1004, mask 0000, core_gnt_out cycle 1, core_done_out cycle 2 with rdata 0xDEAD_BEEF.
REQ-030 Ext write addr 0x20, wdata 0x0000_AB00, mask 0010, ack delayed 3 cycles -> mem_* stable 4 cycles, ext_done_out one pulse after ack, ext_rdata_out 0.
REQ-031 Both request continuously, RR enabled, after reset -> grants alternate CORE, EXT, CORE, EXT; RR disabled -> CORE every time.
REQ-032 reset_in asserted while BUSY awaiting ack -> mem_req_out 0 next cycle, no done pulse, later ack ignored.
REQ-033 Spurious mem_ack_in in IDLE with no requests -> all outputs remain at reset values.
